pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
Parametrised programmable timing generator. A shared period counter drives N_CH control outputs; each output pulses when the counter hits one of its run-time programmable compare slots. Supports free-running and one-shot modes, pause/stop and wrap indication. Sits in the control path as the general replacement for hard-coded counter-decode pulse generators.

Parameters:
CNT_W, 5, counter and compare-value width (bits)
N_CH, 4, number of independent control outputs
N_SLOT, 4, compare slots per channel

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
i_enable  in  1  count enable; low = pause (hold count, outputs 0)
i_start  in  1  single-cycle start request
i_stop  in  1  single-cycle synchronous abort to IDLE
i_mode  in  1  0 = free-run, 1 = one-shot; sampled on accepted start
i_period  in  CNT_W  terminal count; counter runs 0..i_period inclusive
i_cfg_we  in  1  slot table write strobe
i_cfg_ch  in  max(1,$clog2(N_CH))  channel index of write
i_cfg_slot  in  max(1,$clog2(N_SLOT))  slot index of write
i_cfg_val  in  CNT_W  compare value
i_cfg_valid  in  1  slot valid bit written with value
o_ctrl  out  N_CH  registered per-channel pulse
o_wrap  out  1  registered single-cycle pulse at terminal count
o_busy  out  1  high while state = RUN
o_count  out  CNT_W  current counter value

Behaviour:
- Reset (async, reset_n=0): state IDLE, count 0, mode_q 0, all slots valid=0/value=0, o_ctrl 0, o_wrap 0, o_busy 0. Reset mid-run aborts immediately; no pulse emitted after release until a new start.
- States: IDLE, RUN.
- IDLE: count held 0, o_ctrl 0. i_start=1 and i_enable=1 and i_stop=0 -> RUN, mode_q <= i_mode. Start with i_enable=0 ignored.
- RUN, i_enable=1: if count >= i_period: count <= 0, o_wrap <= 1; free-run stays RUN, one-shot -> IDLE. Else count <= count+1.
- RUN, i_enable=0: count held, o_ctrl and o_wrap forced 0 next cycle.
- i_stop=1 in RUN: -> IDLE, count <= 0, no o_wrap; stop beats wrap and start in same cycle. i_start in RUN ignored (no restart).
- Match: o_ctrl[c] <= (state==RUN) & i_enable & OR over slots (valid & value==count). Latency: o_ctrl high exactly the cycle after count equals the slot value (one-cycle pulse per hit). Duplicate slots with same value give one pulse, not wider.
- Compare values > i_period never match. i_period=0: count stays 0, o_wrap every enabled cycle, slot value 0 pulses every cycle.
- i_period lowered below current count: next enabled cycle treated as terminal (>= compare), wrap to 0.
- Count arithmetic unsigned modulo 2^CNT_W; i_period=2^CNT_W-1 gives natural full-range wrap.
- Config write: takes effect on clock edge; the new value is used for compare starting the following cycle. Writes allowed in any state; out-of-range ch/slot indices (non-power-of-2 N_CH/N_SLOT) ignored.
- Same-cycle write and match on the same slot: compare uses old slot contents.

Decomposition:
- Package pulse_seq_pkg: state enum (IDLE, RUN), mode constants MODE_FREE=0, MODE_ONESHOT=1.
- Sub-module pulse_seq_channel: one channel's N_SLOT slot table, write decode and OR-of-compares; instantiated N_CH times by generate. Top holds counter, FSM, output registers.

Test Plan:
- Defaults, ch0 slots {4,20,24} valid, period=31, free-run, start -> o_ctrl[0] high the cycle after count=4,20,24, repeating every 32 cycles; o_wrap after count=31.
- One-shot, period=9, ch1 slot=9 -> single o_ctrl[1] pulse coinciding with o_wrap, then o_busy=0, count 0, no further pulses.
- Pause: free-run period=15, drop i_enable at count=6 for 3 cycles with slot=7 -> count holds 6, no pulses; resume, pulse after count=7.
- i_stop at count=3 with slot=3 in same cycle -> IDLE, count 0, o_wrap 0; o_ctrl pulse for slot 3 still issued (match registered that cycle).
- Reconfigure during run: slot0 ch2 4->10 written at count=4 -> pulse from old value 4; later cycles pulse at 10 only.
- Async reset asserted mid-run at count=12 -> all outputs 0 immediately; slot table cleared; start after release produces no pulses until slots rewritten.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer.
//   state_e      : sequencer FSM state (idle / running)
//   MODE_FREE    : counter wraps and keeps running
//   MODE_ONESHOT : counter wraps once, then returns to idle
package pulse_seq_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_seq_channel.sv
// One output channel of the pulse sequencer: a table of N_SLOT compare slots,
// each holding a value and a valid bit, plus the OR of all slot compares.
//   clock, reset_n : clock / async active-low reset (clears the table)
//   cfg_we         : write strobe for the shared configuration bus
//   cfg_ch         : channel index; the write applies only when it equals CH_IDX
//   cfg_slot       : slot index within the channel
//   cfg_val        : compare value to store
//   cfg_valid      : valid bit to store alongside the value
//   count          : current sequencer count
//   period         : terminal count; slot values above it never match
//   hit            : combinational, some valid slot equals count
module pulse_seq_channel #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned N_SLOT = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned SLOT_W = 2,
  parameter int unsigned CH_IDX = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [CNT_W-1:0]  cfg_val,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  period,
  output logic              hit
);

  logic [CNT_W-1:0] slot_val_q [N_SLOT];
  logic             slot_vld_q [N_SLOT];
  logic             ch_sel;

  assign ch_sel = cfg_we && (cfg_ch == CH_W'(CH_IDX));

  // Indices that decode to no existing slot simply never select one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(N_SLOT); s++) begin
        slot_val_q[s] <= '0;
        slot_vld_q[s] <= 1'b0;
      end
    end else if (ch_sel) begin
      for (int s = 0; s < int'(N_SLOT); s++) begin
        if (cfg_slot == SLOT_W'(s)) begin
          slot_val_q[s] <= cfg_val;
          slot_vld_q[s] <= cfg_valid;
        end
      end
    end
  end

  // Reads the registered table, so a same-cycle write still compares old contents.
  always_comb begin
    hit = 1'b0;
    for (int s = 0; s < int'(N_SLOT); s++) begin
      if (slot_vld_q[s] && (slot_val_q[s] == count) && (slot_val_q[s] <= period)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable timing generator. A shared period counter runs 0..i_period and
// each of N_CH outputs pulses one cycle after the count equals one of its
// programmable compare slots.
//   clock, reset_n : clock / async active-low reset
//   i_enable       : count enable; low pauses the count and blanks outputs
//   i_start        : start request (accepted in idle with i_enable high)
//   i_stop         : synchronous abort to idle, beats wrap and start
//   i_mode         : 0 free-run, 1 one-shot; captured on an accepted start
//   i_period       : terminal count
//   i_cfg_*        : slot table write port (channel, slot, value, valid)
//   o_ctrl         : registered per-channel pulses
//   o_wrap         : registered pulse after the terminal count
//   o_busy         : high while running
//   o_count        : current counter value
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned N_SLOT = 4
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic                                         i_enable,
  input  logic                                         i_start,
  input  logic                                         i_stop,
  input  logic                                         i_mode,
  input  logic [CNT_W-1:0]                             i_period,
  input  logic                                         i_cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   i_cfg_ch,
  input  logic [((N_SLOT > 1) ? $clog2(N_SLOT) : 1)-1:0] i_cfg_slot,
  input  logic [CNT_W-1:0]                             i_cfg_val,
  input  logic                                         i_cfg_valid,
  output logic [N_CH-1:0]                              o_ctrl,
  output logic                                         o_wrap,
  output logic                                         o_busy,
  output logic [CNT_W-1:0]                             o_count
);

  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] count_q;
  logic [N_CH-1:0]  ctrl_q;
  logic             wrap_q;
  logic [N_CH-1:0]  hit;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    pulse_seq_channel #(
      .CNT_W  (CNT_W),
      .N_SLOT (N_SLOT),
      .CH_W   (CH_W),
      .SLOT_W (SLOT_W),
      .CH_IDX (c)
    ) u_channel (
      .clock     (clock),
      .reset_n   (reset_n),
      .cfg_we    (i_cfg_we),
      .cfg_ch    (i_cfg_ch),
      .cfg_slot  (i_cfg_slot),
      .cfg_val   (i_cfg_val),
      .cfg_valid (i_cfg_valid),
      .count     (count_q),
      .period    (i_period),
      .hit       (hit[c])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= MODE_FREE;
      count_q <= '0;
      ctrl_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      // Outputs are single-cycle pulses unless re-asserted below.
      ctrl_q <= '0;
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          count_q <= '0;
          if (i_start && i_enable && !i_stop) begin
            state_q <= StRun;
            mode_q  <= i_mode;
          end
        end
        StRun: begin
          // The match is registered even on a stop cycle.
          if (i_enable) begin
            ctrl_q <= hit;
          end
          if (i_stop) begin
            state_q <= StIdle;
            count_q <= '0;
          end else if (i_enable) begin
            // >= also catches a period lowered below the current count.
            if (count_q >= i_period) begin
              count_q <= '0;
              wrap_q  <= 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_q <= StIdle;
              end
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ctrl  = ctrl_q;
  assign o_wrap  = wrap_q;
  assign o_busy  = (state_q == StRun);
  assign o_count = count_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
module tb_pulse_sequencer;

  localparam int CNT_W  = 5;
  localparam int N_CH   = 4;
  localparam int N_SLOT = 4;
  localparam int CH_W   = 2;
  localparam int SL_W   = 2;
  localparam int VW     = CNT_W + N_CH + 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_enable = 1'b0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_mode = 1'b0;
  logic [CNT_W-1:0] i_period = '0;
  logic             i_cfg_we = 1'b0;
  logic [CH_W-1:0]  i_cfg_ch = '0;
  logic [SL_W-1:0]  i_cfg_slot = '0;
  logic [CNT_W-1:0] i_cfg_val = '0;
  logic             i_cfg_valid = 1'b0;
  logic [N_CH-1:0]  o_ctrl;
  logic             o_wrap;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;

  pulse_sequencer #(
    .CNT_W  (CNT_W),
    .N_CH   (N_CH),
    .N_SLOT (N_SLOT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_enable    (i_enable),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .i_period    (i_period),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_slot  (i_cfg_slot),
    .i_cfg_val   (i_cfg_val),
    .i_cfg_valid (i_cfg_valid),
    .o_ctrl      (o_ctrl),
    .o_wrap      (o_wrap),
    .o_busy      (o_busy),
    .o_count     (o_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: running flag, integer count, slot table as plain arrays.
  bit              m_run;
  bit              m_mode;
  int              m_cnt;
  logic [N_CH-1:0] m_ctrl;
  bit              m_wrap;
  int              m_val [N_CH][N_SLOT];
  bit              m_vld [N_CH][N_SLOT];

  logic [VW-1:0] exp_v, got_v;

  task automatic model_clear();
    m_run = 0; m_mode = 0; m_cnt = 0; m_ctrl = '0; m_wrap = 0;
    for (int c = 0; c < N_CH; c++)
      for (int s = 0; s < N_SLOT; s++) begin
        m_val[c][s] = 0;
        m_vld[c][s] = 0;
      end
  endtask

  function automatic logic [VW-1:0] model_vec();
    return {m_run, m_wrap, m_ctrl, CNT_W'(m_cnt)};
  endfunction

  // Advance model and DUT by one clock; inputs are sampled as currently driven.
  task automatic cycle();
    logic [N_CH-1:0] nc;
    bit nw;
    int per;
    nc = '0; nw = 0; per = int'(i_period);
    if (m_run && i_enable)
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_SLOT; s++)
          if (m_vld[c][s] && m_val[c][s] == m_cnt && m_val[c][s] <= per) nc[c] = 1'b1;
    if (m_run) begin
      if (i_stop) begin
        m_run = 0; m_cnt = 0;
      end else if (i_enable) begin
        if (m_cnt >= per) begin
          nw = 1; m_cnt = 0;
          if (m_mode) m_run = 0;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end else if (i_start && i_enable && !i_stop) begin
      m_run = 1; m_mode = i_mode;
    end
    if (i_cfg_we && int'(i_cfg_ch) < N_CH && int'(i_cfg_slot) < N_SLOT) begin
      m_val[i_cfg_ch][i_cfg_slot] = int'(i_cfg_val);
      m_vld[i_cfg_ch][i_cfg_slot] = i_cfg_valid;
    end
    @(posedge clock);
    m_ctrl = nc; m_wrap = nw;
    #1;
    i_start = 0; i_stop = 0; i_cfg_we = 0;
  endtask

  task automatic write_slot(input int ch, input int slot, input int val, input bit vld);
    i_cfg_we = 1; i_cfg_ch = CH_W'(ch); i_cfg_slot = SL_W'(slot);
    i_cfg_val = CNT_W'(val); i_cfg_valid = vld;
    cycle();
  endtask

  task automatic start_run(input int per, input bit mode);
    i_period = CNT_W'(per); i_mode = mode; i_enable = 1; i_start = 1;
    cycle();
  endtask

  task automatic stop_run();
    i_stop = 1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset_n = 0;
    #2;
    checks++;
    if (o_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", o_ctrl); end
    checks++;
    if (o_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", o_wrap); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++;
    if (o_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    model_clear();
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;
    i_start = 1; // start with enable low must be ignored
    cycle();
    got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
    checks++;
    if (got_v !== exp_v || o_busy !== 1'b0) begin
      errors++; $display("FAIL start_disabled: got %h want %h", got_v, exp_v);
    end
  endtask

  task automatic test_free_run();
    int pulses, wraps;
    bit exp_p;
    write_slot(0, 0, 4, 1);
    write_slot(0, 1, 20, 1);
    write_slot(0, 2, 24, 1);
    start_run(31, 0);
    pulses = 0; wraps = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL free_run_model cyc%0d: got %h want %h", i, got_v, exp_v);
      end
      exp_p = ((i % 32) == 4) || ((i % 32) == 20) || ((i % 32) == 24);
      checks++;
      if (o_ctrl[0] !== exp_p || o_wrap !== ((i % 32) == 31)) begin
        errors++;
        $display("FAIL free_run_pulse cyc%0d: got ctrl0=%b wrap=%b want %b %b",
                 i, o_ctrl[0], o_wrap, exp_p, (i % 32) == 31);
      end
      if (o_ctrl[0] === 1'b1) pulses++;
      if (o_wrap === 1'b1) wraps++;
    end
    checks++;
    if (pulses != 6 || wraps != 2) begin
      errors++; $display("FAIL free_run_totals: got %0d/%0d want 6/2", pulses, wraps);
    end
    stop_run();
  endtask

  task automatic test_oneshot();
    write_slot(1, 0, 9, 1);
    start_run(9, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL oneshot_model cyc%0d: got %h want %h", i, got_v, exp_v);
      end
    end
    checks++;
    if (o_wrap !== 1'b1 || o_ctrl[1] !== 1'b1 || o_busy !== 1'b0 || o_count !== '0) begin
      errors++;
      $display("FAIL oneshot_end: got wrap=%b ctrl1=%b busy=%b cnt=%0d want 1 1 0 0",
               o_wrap, o_ctrl[1], o_busy, o_count);
    end
    for (int i = 0; i < 15; i++) begin
      cycle();
      checks++;
      if (o_ctrl !== '0 || o_busy !== 1'b0 || o_wrap !== 1'b0) begin
        errors++; $display("FAIL oneshot_quiet cyc%0d: got ctrl=%b busy=%b want 0 0",
                           i, o_ctrl, o_busy);
      end
    end
  endtask

  task automatic test_pause();
    write_slot(3, 0, 7, 1);
    start_run(15, 0);
    repeat (6) cycle();
    checks++;
    if (o_count !== 5'd6) begin errors++; $display("FAIL pause_pre: got %0d want 6", o_count); end
    i_enable = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_count !== 5'd6 || o_ctrl !== '0 || o_wrap !== 1'b0 || o_busy !== 1'b1) begin
        errors++; $display("FAIL pause_hold cyc%0d: got cnt=%0d ctrl=%b want 6 0",
                           i, o_count, o_ctrl);
      end
    end
    i_enable = 1;
    cycle();
    checks++;
    if (o_count !== 5'd7 || o_ctrl[3] !== 1'b0) begin
      errors++; $display("FAIL pause_resume: got cnt=%0d ctrl3=%b want 7 0", o_count, o_ctrl[3]);
    end
    cycle();
    checks++;
    if (o_count !== 5'd8 || o_ctrl[3] !== 1'b1) begin
      errors++; $display("FAIL pause_pulse: got cnt=%0d ctrl3=%b want 8 1", o_count, o_ctrl[3]);
    end
    stop_run();
  endtask

  task automatic test_stop();
    write_slot(2, 1, 3, 1);
    start_run(31, 0);
    repeat (3) cycle();
    i_stop = 1; i_start = 1;
    cycle();
    got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
    checks++;
    if (o_busy !== 1'b0 || o_count !== '0 || o_wrap !== 1'b0 || o_ctrl[2] !== 1'b1) begin
      errors++; $display("FAIL stop_abort: got busy=%b cnt=%0d wrap=%b ctrl2=%b want 0 0 0 1",
                         o_busy, o_count, o_wrap, o_ctrl[2]);
    end
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL stop_model: got %h want %h", got_v, exp_v); end
    cycle();
  endtask

  task automatic test_reconfig();
    int pulses;
    write_slot(2, 1, 3, 0);
    write_slot(2, 0, 4, 1);
    start_run(31, 0);
    repeat (4) cycle();
    i_cfg_we = 1; i_cfg_ch = 2'd2; i_cfg_slot = 2'd0; i_cfg_val = 5'd10; i_cfg_valid = 1;
    cycle();
    checks++;
    if (o_ctrl[2] !== 1'b1 || o_count !== 5'd5) begin
      errors++; $display("FAIL reconfig_old: got ctrl2=%b cnt=%0d want 1 5", o_ctrl[2], o_count);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL reconfig_model cyc%0d: got %h want %h", i, got_v, exp_v);
      end
      if (o_ctrl[2] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL reconfig_new: got %0d pulses want 1", pulses); end
    stop_run();
  endtask

  task automatic test_period_zero();
    write_slot(0, 3, 0, 1);
    start_run(0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (o_wrap !== 1'b1 || o_ctrl[0] !== 1'b1 || o_count !== '0 || o_busy !== 1'b1) begin
        errors++; $display("FAIL period_zero cyc%0d: got wrap=%b ctrl0=%b cnt=%0d want 1 1 0",
                           i, o_wrap, o_ctrl[0], o_count);
      end
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    start_run(31, 0);
    repeat (12) cycle();
    checks++;
    if (o_count !== 5'd12) begin errors++; $display("FAIL areset_pre: got %0d want 12", o_count); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({o_busy, o_wrap, o_ctrl, o_count} !== '0) begin
      errors++; $display("FAIL areset_now: got %h want 0", {o_busy, o_wrap, o_ctrl, o_count});
    end
    model_clear();
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;
    start_run(31, 0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
      checks++;
      if (got_v !== exp_v || o_ctrl !== '0) begin
        errors++; $display("FAIL areset_after cyc%0d: got %h want %h", i, got_v, exp_v);
      end
    end
    stop_run();
  endtask

  task automatic test_random();
    i_period = 5'd12;
    for (int i = 0; i < 800; i++) begin
      i_enable = ($urandom % 8) != 0;
      i_start  = ($urandom % 6) == 0;
      i_stop   = ($urandom % 30) == 0;
      i_mode   = $urandom % 2;
      if (($urandom % 25) == 0)
        i_period = (($urandom % 4) == 0) ? CNT_W'($urandom_range(0, 31))
                                         : CNT_W'($urandom_range(0, 10));
      if (($urandom % 3) == 0) begin
        i_cfg_we    = 1;
        i_cfg_ch    = CH_W'($urandom);
        i_cfg_slot  = SL_W'($urandom);
        i_cfg_val   = CNT_W'($urandom_range(0, 14));
        i_cfg_valid = ($urandom % 4) != 0;
      end
      cycle();
      got_v = {o_busy, o_wrap, o_ctrl, o_count}; exp_v = model_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_oneshot();
    test_pause();
    test_stop();
    test_reconfig();
    test_period_zero();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
